// File: rtl/ysyx_24080014_arb_pkg.sv
// Shared types for the N-master memory arbiter.
// Provides the FSM state encoding and a width helper.
package ysyx_24080014_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_TERR = 2'd3
  } arb_state_e;

  // $clog2 that never returns 0, so 1-entry things still get a bit
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_24080014_rr_pick.sv
// Combinational grant picker: fixed priority or round-robin.
// Ports: req vector, last winner, rr mode -> win index, any request.
module ysyx_24080014_rr_pick
  import ysyx_24080014_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          rr,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    any   = |req;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    if (rr) begin
      // search last+1, last+2, ... wrapping; first hit wins
      for (int k = 1; k <= N; k++) begin
        idx = IW'((int'(last) + k) % N);
        if (!found && req[idx]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end else begin
      // scan downward so the lowest set index is the last write
      for (int i = N - 1; i >= 0; i--) begin
        idx = IW'(i);
        if (req[idx]) win = idx;
      end
    end
  end

endmodule

// File: rtl/ysyx_24080014_mem_arb.sv
// N-master to 1-slave memory arbiter with valid/ready on req and resp.
// Masters: packed m_req_*, routed m_resp_valid; slave: s_req_*/s_resp_*; busy/owner status.
module ysyx_24080014_mem_arb
  import ysyx_24080014_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MST-1:0]             m_req_valid,
  output logic [NUM_MST-1:0]             m_req_ready,
  input  logic [NUM_MST*AW-1:0]          m_req_addr,
  input  logic [NUM_MST-1:0]             m_req_wen,
  input  logic [NUM_MST*DW-1:0]          m_req_wdata,
  input  logic [NUM_MST*DW/8-1:0]        m_req_wmask,
  output logic [NUM_MST-1:0]             m_resp_valid,
  input  logic [NUM_MST-1:0]             m_resp_ready,
  output logic [DW-1:0]                  m_resp_rdata,
  output logic                           m_resp_err,
  output logic                           s_req_valid,
  input  logic                           s_req_ready,
  output logic [AW-1:0]                  s_req_addr,
  output logic                           s_req_wen,
  output logic [DW-1:0]                  s_req_wdata,
  output logic [DW/8-1:0]                s_req_wmask,
  input  logic                           s_resp_valid,
  output logic                           s_resp_ready,
  input  logic [DW-1:0]                  s_resp_rdata,
  input  logic                           s_resp_err,
  output logic                           busy,
  output logic [clog2_min1(NUM_MST)-1:0] owner
);

  localparam int IW       = clog2_min1(NUM_MST);
  localparam int MW       = DW / 8;
  localparam int CW       = clog2_min1(TIMEOUT + 1);
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TMO_LAST_C = CW'(TMO_LAST);

  arb_state_e    state;
  logic [IW-1:0] last;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win;
  logic          any;
  logic          own_rready;
  logic          tmo_hit;

  logic [AW-1:0] addr_a  [NUM_MST];
  logic [DW-1:0] wdata_a [NUM_MST];
  logic [MW-1:0] wmask_a [NUM_MST];

  for (genvar i = 0; i < NUM_MST; i++) begin : g_unpack
    assign addr_a[i]  = m_req_addr[i*AW +: AW];
    assign wdata_a[i] = m_req_wdata[i*DW +: DW];
    assign wmask_a[i] = m_req_wmask[i*MW +: MW];
  end

  ysyx_24080014_rr_pick #(
    .N  (NUM_MST),
    .IW (IW)
  ) u_pick (
    .req  (m_req_valid),
    .last (last),
    .rr   (RR != 0),
    .win  (win),
    .any  (any)
  );

  assign own_rready = m_resp_ready[owner];
  assign busy       = (state != ST_IDLE);

  // counter parks at TIMEOUT-1, so a held-but-unaccepted
  // response cannot wrap it past the expiry point
  assign tmo_hit = (TIMEOUT > 0) && !s_resp_valid
                && (cnt == TMO_LAST_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= '0;
      last  <= IW'(NUM_MST - 1);
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            owner <= win;
            last  <= win;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (s_req_ready) begin
            cnt   <= '0;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (s_resp_valid && own_rready) begin
            state <= ST_IDLE;
          end else begin
            if (tmo_hit) state <= ST_TERR;
            if (cnt != TMO_LAST_C) cnt <= cnt + CW'(1);
          end
        end
        ST_TERR: begin
          if (own_rready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_req_ready  = '0;
    m_resp_valid = '0;
    m_resp_rdata = '0;
    m_resp_err   = 1'b0;
    s_req_valid  = 1'b0;
    s_req_addr   = '0;
    s_req_wen    = 1'b0;
    s_req_wdata  = '0;
    s_req_wmask  = '0;
    s_resp_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // soak up stray slave responses, but stay quiet in reset
        s_resp_ready = rst;
      end
      ST_REQ: begin
        s_req_valid        = 1'b1;
        s_req_addr         = addr_a[owner];
        s_req_wen          = m_req_wen[owner];
        s_req_wdata        = wdata_a[owner];
        s_req_wmask        = wmask_a[owner];
        m_req_ready[owner] = s_req_ready;
      end
      ST_RESP: begin
        m_resp_valid[owner] = s_resp_valid;
        m_resp_rdata        = s_resp_rdata;
        m_resp_err          = s_resp_err;
        s_resp_ready        = own_rready;
      end
      ST_TERR: begin
        m_resp_valid[owner] = 1'b1;
        m_resp_err          = 1'b1;
        s_resp_ready        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24080014_mem_arb.sv
// Randomized bench for the memory arbiter against a transaction model.
// Two instances: 3-master round-robin with timeout, 2-master fixed priority.
module tb_ysyx_24080014_mem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit done [2];

  function automatic void chk(input int g, input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL inst%0d %s: got %0h expected %0h @%0t",
               g, nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int N   = (g == 0) ? 3 : 2;
    localparam int RRP = (g == 0) ? 1 : 0;
    localparam int TO  = (g == 0) ? 8 : 0;
    localparam int IW  = (N > 2) ? 2 : 1;

    logic            rst = 1'b0;
    logic [N-1:0]    m_req_valid = '0;
    logic [N-1:0]    m_req_ready;
    logic [31:0]     ma [N] = '{default: '0};
    logic [N-1:0]    m_req_wen = '0;
    logic [31:0]     md [N] = '{default: '0};
    logic [3:0]      mm [N] = '{default: '0};
    logic [N*32-1:0] m_req_addr;
    logic [N*32-1:0] m_req_wdata;
    logic [N*4-1:0]  m_req_wmask;
    logic [N-1:0]    m_resp_valid;
    logic [N-1:0]    m_resp_ready = '0;
    logic [31:0]     m_resp_rdata;
    logic            m_resp_err;
    logic            s_req_valid;
    logic            s_req_ready = 1'b0;
    logic [31:0]     s_req_addr;
    logic            s_req_wen;
    logic [31:0]     s_req_wdata;
    logic [3:0]      s_req_wmask;
    logic            s_resp_valid = 1'b0;
    logic            s_resp_ready;
    logic [31:0]     s_resp_rdata = '0;
    logic            s_resp_err = 1'b0;
    logic            busy;
    logic [IW-1:0]   owner;

    for (genvar i = 0; i < N; i++) begin : g_pack
      assign m_req_addr[i*32 +: 32]  = ma[i];
      assign m_req_wdata[i*32 +: 32] = md[i];
      assign m_req_wmask[i*4 +: 4]   = mm[i];
    end

    ysyx_24080014_mem_arb #(
      .NUM_MST (N),
      .AW      (32),
      .DW      (32),
      .RR      (RRP),
      .TIMEOUT (TO)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .m_req_valid  (m_req_valid),
      .m_req_ready  (m_req_ready),
      .m_req_addr   (m_req_addr),
      .m_req_wen    (m_req_wen),
      .m_req_wdata  (m_req_wdata),
      .m_req_wmask  (m_req_wmask),
      .m_resp_valid (m_resp_valid),
      .m_resp_ready (m_resp_ready),
      .m_resp_rdata (m_resp_rdata),
      .m_resp_err   (m_resp_err),
      .s_req_valid  (s_req_valid),
      .s_req_ready  (s_req_ready),
      .s_req_addr   (s_req_addr),
      .s_req_wen    (s_req_wen),
      .s_req_wdata  (s_req_wdata),
      .s_req_wmask  (s_req_wmask),
      .s_resp_valid (s_resp_valid),
      .s_resp_ready (s_resp_ready),
      .s_resp_rdata (s_resp_rdata),
      .s_resp_err   (s_resp_err),
      .busy         (busy),
      .owner        (owner)
    );

    // stimulus knobs (percent probabilities) and enabled masters
    int     p_req = 0;
    int     p_sready = 0;
    int     p_rvalid = 0;
    int     p_mready = 0;
    logic [N-1:0] men = '0;
    bit     chk_on = 1'b0;

    // transaction model: no txn / granted / accepted / errored
    localparam int PH_NONE = 0;
    localparam int PH_GNT  = 1;
    localparam int PH_ACC  = 2;
    localparam int PH_ERR  = 3;
    int mst = PH_NONE;
    int mown = 0;
    int mlast = N - 1;
    int mwait = 0;
    int grants [$];

    function automatic int pick(input logic [N-1:0] v,
                                input int lst);
      int order [$];
      order = {};
      for (int k = 1; k <= N; k++)
        order.push_back((RRP != 0) ? (lst + k) % N : k - 1);
      foreach (order[j])
        if (v[order[j]]) return order[j];
      return 0;
    endfunction

    initial begin : drv
      logic [N-1:0] rdy_s;
      logic [N-1:0] ev;
      logic [N-1:0] erv;
      logic         ers;
      rdy_s = '0;
      forever begin
        @(negedge clk);
        rdy_s = m_req_ready;
        if (rst && chk_on) begin
          ev  = '0;
          erv = '0;
          if (mst == PH_GNT && s_req_ready) ev[mown] = 1'b1;
          if ((mst == PH_ACC && s_resp_valid) || mst == PH_ERR)
            erv[mown] = 1'b1;
          chk(g, "busy", 64'(busy), 64'(mst != PH_NONE));
          chk(g, "owner", 64'(owner), 64'(mown));
          chk(g, "m_req_ready", 64'(m_req_ready), 64'(ev));
          chk(g, "s_req_valid", 64'(s_req_valid),
              64'(mst == PH_GNT));
          chk(g, "m_resp_valid", 64'(m_resp_valid), 64'(erv));
          if (mst == PH_GNT) begin
            chk(g, "s_req_addr", 64'(s_req_addr), 64'(ma[mown]));
            chk(g, "s_req_wen", 64'(s_req_wen),
                64'(m_req_wen[mown]));
            chk(g, "s_req_wdata", 64'(s_req_wdata), 64'(md[mown]));
            chk(g, "s_req_wmask", 64'(s_req_wmask), 64'(mm[mown]));
          end else begin
            ers = (mst == PH_ACC) ? m_resp_ready[mown] : 1'b1;
            chk(g, "s_resp_ready", 64'(s_resp_ready), 64'(ers));
          end
          if (mst == PH_ACC && s_resp_valid) begin
            chk(g, "rdata", 64'(m_resp_rdata), 64'(s_resp_rdata));
            chk(g, "err", 64'(m_resp_err), 64'(s_resp_err));
          end
          if (mst == PH_ERR) begin
            chk(g, "terr_rdata", 64'(m_resp_rdata), 64'd0);
            chk(g, "terr_err", 64'(m_resp_err), 64'd1);
          end
        end
        @(posedge clk);
        if (!rst) begin
          mst   = PH_NONE;
          mown  = 0;
          mlast = N - 1;
          mwait = 0;
        end else begin
          case (mst)
            PH_NONE: if (|m_req_valid) begin
              mown  = pick(m_req_valid, mlast);
              mlast = mown;
              mst   = PH_GNT;
            end
            PH_GNT: if (s_req_ready) begin
              grants.push_back(mown);
              mwait = 0;
              mst   = PH_ACC;
            end
            PH_ACC: begin
              if (s_resp_valid && m_resp_ready[mown])
                mst = PH_NONE;
              else if (TO > 0 && !s_resp_valid && mwait >= TO - 1)
                mst = PH_ERR;
              else
                mwait++;
            end
            default: if (m_resp_ready[mown]) mst = PH_NONE;
          endcase
        end
        #1;
        for (int i = 0; i < N; i++) begin
          if (m_req_valid[i] && rdy_s[i]) m_req_valid[i] = 1'b0;
          if (!m_req_valid[i] && men[i]
              && int'($urandom % 100) < p_req) begin
            m_req_valid[i] = 1'b1;
            ma[i]          = $urandom;
            md[i]          = $urandom;
            mm[i]          = 4'($urandom);
            m_req_wen[i]   = 1'($urandom);
          end
          m_resp_ready[i] = int'($urandom % 100) < p_mready;
        end
        s_req_ready  = int'($urandom % 100) < p_sready;
        s_resp_valid = int'($urandom % 100) < p_rvalid;
        s_resp_rdata = $urandom;
        s_resp_err   = ($urandom % 4) == 0;
      end
    end

    initial begin : ctl
      int n;
      int gs;
      repeat (3) @(negedge clk);
      chk(g, "rst_busy", 64'(busy), 64'd0);
      chk(g, "rst_owner", 64'(owner), 64'd0);
      chk(g, "rst_m_req_ready", 64'(m_req_ready), 64'd0);
      chk(g, "rst_s_req_valid", 64'(s_req_valid), 64'd0);
      chk(g, "rst_s_req_addr", 64'(s_req_addr), 64'd0);
      chk(g, "rst_m_resp_valid", 64'(m_resp_valid), 64'd0);
      chk(g, "rst_s_resp_ready", 64'(s_resp_ready), 64'd0);
      #2 rst = 1'b1;
      chk_on = 1'b1;

      // two masters hammering: grant order and request latency
      men      = '0;
      men[0]   = 1'b1;
      men[1]   = 1'b1;
      p_req    = 100;
      p_sready = 100;
      p_rvalid = 100;
      p_mready = 100;
      n = 0;
      while (!m_req_valid[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk(g, "first_valid", 64'(m_req_valid[0]), 64'd1);
      chk(g, "ready_same_cycle", 64'(m_req_ready[0]), 64'd0);
      @(negedge clk);
      chk(g, "ready_next_cycle", 64'(m_req_ready[0]), 64'd1);
      n = 0;
      while (grants.size() < 4 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk(g, "four_grants", 64'(grants.size() >= 4), 64'd1);
      for (int k = 0; k < 4 && k < grants.size(); k++)
        chk(g, $sformatf("grant%0d", k), 64'(grants[k]),
            64'((k % 2) * RRP));

      // random traffic from every master
      men      = '1;
      p_req    = 50;
      p_sready = 60;
      p_rvalid = 35;
      p_mready = 70;
      repeat (1500) @(negedge clk);

      // drain, then a single read the slave never answers
      p_req    = 0;
      p_sready = 100;
      p_rvalid = 100;
      p_mready = 100;
      n = 0;
      while ((mst != PH_NONE || |m_req_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk(g, "drained", 64'(mst == PH_NONE && ~|m_req_valid), 64'd1);
      men      = '0;
      men[0]   = 1'b1;
      p_rvalid = 0;
      p_req    = 100;
      gs = grants.size();
      n = 0;
      while (grants.size() == gs && n < 50) begin
        @(negedge clk);
        n++;
      end
      p_req = 0;
      chk(g, "tmo_accept", 64'(grants.size() > gs), 64'd1);
      n = 0;
      while (~|m_resp_valid && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk(g, "tmo_cycles", 64'(n), 64'((TO > 0) ? TO : 20));
      chk(g, "tmo_valid", 64'(m_resp_valid), 64'((TO > 0) ? 1 : 0));
      p_rvalid = 100;
      p_mready = 0;
      repeat (3) @(negedge clk);
      p_mready = 100;
      repeat (4) @(negedge clk);

      // asynchronous reset while a response is outstanding
      men      = '1;
      p_req    = 100;
      p_rvalid = 0;
      n = 0;
      while (mst != PH_ACC && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk(g, "reach_resp", 64'(mst == PH_ACC), 64'd1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk(g, "arst_busy", 64'(busy), 64'd0);
      chk(g, "arst_m_resp_valid", 64'(m_resp_valid), 64'd0);
      chk(g, "arst_m_req_ready", 64'(m_req_ready), 64'd0);
      chk(g, "arst_s_req_valid", 64'(s_req_valid), 64'd0);
      chk(g, "arst_owner", 64'(owner), 64'd0);
      grants.delete();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      p_rvalid = 100;
      n = 0;
      while (grants.size() == 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk(g, "post_rst_grant_seen", 64'(grants.size() > 0), 64'd1);
      if (grants.size() > 0)
        chk(g, "post_rst_grant", 64'(grants[0]), 64'd0);
      repeat (5) @(negedge clk);
      done[g] = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: done %0d%0d expected 11", done[0], done[1]);
    $fatal(1);
  end

  initial begin
    wait (done[0] && done[1]);
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_24080014_mem_arb.md
Name: ysyx_24080014_mem_arb

Overview:
- Parametrised N-master to 1-slave memory arbiter for the multi-cycle core.
- Generalises the current ad-hoc IFU/LSU sharing (inst_ready/mem_ready) to NUM_MST requesters with valid/ready handshakes on both request and response channels.
- Adds a selectable arbitration mode (fixed priority or round-robin) and an optional response timeout with error reporting.
- Sits between IF/LSU (and later DMA/debug masters) and the single memory/bus port.

Parameters:
- NUM_MST, 2, number of masters (2..8); index 0 is highest priority in fixed mode.
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- RR, 1, 1 = round-robin, 0 = fixed priority.
- TIMEOUT, 0, cycles allowed in RESP before an error response; 0 = disabled.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_req_valid  in  NUM_MST  per-master request valid.
- m_req_ready  out  NUM_MST  per-master request accepted.
- m_req_addr  in  NUM_MST*AW  packed addresses; master i occupies bits [i*AW +: AW].
- m_req_wen  in  NUM_MST  1 = write, 0 = read.
- m_req_wdata  in  NUM_MST*DW  packed write data.
- m_req_wmask  in  NUM_MST*DW/8  packed byte enables.
- m_resp_valid  out  NUM_MST  response valid, routed to the owner only.
- m_resp_ready  in  NUM_MST  master accepts response.
- m_resp_rdata  out  DW  read data, broadcast; qualified by m_resp_valid.
- m_resp_err  out  1  error flag, broadcast; qualified by m_resp_valid.
- s_req_valid/s_req_ready  out/in  1  slave request handshake.
- s_req_addr/s_req_wen/s_req_wdata/s_req_wmask  out  AW/1/DW/DW/8  request fields of the owner.
- s_resp_valid/s_resp_ready  in/out  1  slave response handshake.
- s_resp_rdata  in  DW  slave read data.
- s_resp_err  in  1  slave error flag.
- busy  out  1  state != IDLE.
- owner  out  $clog2(NUM_MST)  index of the current grant.

Behaviour:
- States: IDLE, REQ, RESP, TERR.
- **Reset (rst=0, asynchronous):**
  - state=IDLE; all valid/ready outputs 0; s_req_* fields 0; busy=0; owner=0; timeout counter 0.
  - RR pointer last=NUM_MST-1, so master 0 wins first.
  - Reset mid-transaction abandons the transaction; no response is produced.
- **IDLE:**
  - If any m_req_valid, register the winner into owner and go to REQ (1 cycle arbitration latency).
  - Fixed mode: lowest set index wins.
  - RR mode: first set index searching last+1, last+2, ... with wrap modulo NUM_MST.
  - Set last=winner on grant.
  - s_resp_ready=1 in IDLE; stray slave responses are absorbed and discarded.
- **REQ:**
  - s_req_valid=1; s_req_* = owner's fields (combinational mux); m_req_ready[owner]=s_req_ready; other readies 0.
  - On s_req_valid&s_req_ready, go to RESP.
  - Masters must hold valid and fields stable until ready; violating this is outside the protocol.
  - No timeout in REQ.
- **RESP:**
  - m_resp_valid[owner]=s_resp_valid; s_resp_ready=m_resp_ready[owner]; rdata/err pass through combinationally.
  - On handshake, go to IDLE.
  - The counter increments each RESP cycle without a handshake.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 with no s_resp_valid, go to TERR.
- **TERR:**
  - m_resp_valid[owner]=1, m_resp_err=1, m_resp_rdata=0; s_resp_ready=1 (drops a late slave response).
  - On m_resp_ready[owner], go to IDLE.
- **Simultaneous events:**
  - Handshake on the same cycle the counter would expire: the handshake wins and no TERR.
  - New requests during a transaction wait; no preemption.
  - An owner dropping valid in REQ is not supported.
- Counter is $clog2(TIMEOUT+1) bits and clears on entering RESP.
- **Throughput:** each transaction takes at least 3 cycles (IDLE, REQ, RESP); back-to-back RR alternates masters under continuous requests.

Decomposition:
- Shared package ysyx_24080014_arb_pkg: state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2, TERR=2'd3) and a function clog2_min1.
- One sub-module, ysyx_24080014_rr_pick: combinational priority picker (req vector, last index, RR mode -> winner index, any).
- The top holds the FSM, muxes and counter.

Test Plan:
- **Reset then single read.** Master0 reads 0x80000000; slave ready=1 and answers 0xDEADBEEF after 2 cycles -> m_resp_valid[0] with rdata=0xDEADBEEF, err=0. m_req_ready[0] fires in the cycle after valid rises. No m_resp_valid[1].
- **Round-robin, RR=1.** Both masters continuously valid -> grants 0,1,0,1. owner toggles each transaction.
- **Fixed priority, RR=0.** Both masters valid -> master0 is granted for 4 consecutive transactions; master1 only after master0 drops valid.
- **Write path.** Master1 writes addr 0x80000010, data 0x12345678, wmask 4'b0011 -> slave sees the exact fields with s_req_wen=1 for the full REQ window, including 2 s_req_ready stall cycles.
- **Timeout.** TIMEOUT=8, slave never responds -> after 8 RESP cycles the owner gets m_resp_valid, err=1, rdata=0. A late s_resp_valid is absorbed and never reaches any master.
- **Async reset mid-RESP.** Assert rst=0 between clock edges -> busy=0 and all valids=0 immediately. The next grant goes to master0.
